// File: rtl/wb_commit_stage.sv
// rtl/wb_commit_stage.sv - rv32i writeback/commit stage with trace queue (optional WB_ORDER_CHECK_EN)
module wb_commit_stage #(
  parameter int DEPTH   = 4,
  parameter int ORDER_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mw_valid,
  output logic               wb_ready,
  input  logic [ORDER_W-1:0] mw_order,
  input  logic [3:0]         mw_sel,
  input  logic               mw_ld_reg,
  input  logic               mw_is_store,
  input  logic [4:0]         mw_rd,
  input  logic [31:0]        alu_out,
  input  logic [31:0]        u_imm,
  input  logic [31:0]        mem_rdata,
  input  logic [31:0]        pc_rdata,
  input  logic               br_en,
  input  logic [1:0]         mem_addr_lo,
  output logic               rf_we,
  output logic [4:0]         rf_rd,
  output logic [31:0]        rf_wdata,
  output logic               trc_valid,
  input  logic               trc_ready,
  output logic [ORDER_W-1:0] trc_order,
  output logic [31:0]        trc_pc,
  output logic [4:0]         trc_rd,
  output logic [31:0]        trc_wdata,
  output logic [31:0]        commit_cnt,
  output logic               order_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ORDER_W-1:0] r_last_order;
  logic               r_last_vld;
  logic [31:0]        r_commit_cnt;
  logic               r_rf_we;
  logic [4:0]         r_rf_rd;
  logic [31:0]        r_rf_wdata;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;

  logic [ORDER_W-1:0] r_q_order [DEPTH];
  logic [31:0]        r_q_pc    [DEPTH];
  logic [4:0]         r_q_rd    [DEPTH];
  logic [31:0]        r_q_wdata [DEPTH];

  logic        w_new;
  logic        w_full;
  logic        w_accept;
  logic        w_deq;
  logic        w_we;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_sel_data;
  logic [4:0]  w_rec_rd;
  logic [31:0] w_rec_wdata;

  // A repeated tag means upstream is stalled on the same instruction; ignore it.
  assign w_new    = mw_valid && (!r_last_vld || (mw_order != r_last_order));
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign wb_ready = !w_full || trc_ready;
  assign w_accept = w_new && wb_ready;
  assign w_deq    = trc_valid && trc_ready;

  // Load alignment and regfilemux selection.
  always_comb begin
    w_byte = 8'h00;
    case (mem_addr_lo)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_sel_data = 32'h0;
    case (mw_sel)
      4'd0:    w_sel_data = alu_out;
      4'd1:    w_sel_data = {31'b0, br_en};
      4'd2:    w_sel_data = u_imm;
      4'd3:    w_sel_data = mem_rdata;
      4'd4:    w_sel_data = pc_rdata + 32'd4;
      4'd5:    w_sel_data = {{24{w_byte[7]}}, w_byte};
      4'd6:    w_sel_data = {24'b0, w_byte};
      4'd7:    w_sel_data = {{16{w_half[15]}}, w_half};
      4'd8:    w_sel_data = {16'b0, w_half};
      default: w_sel_data = 32'h0;
    endcase
    if (mw_is_store) begin
      w_sel_data = 32'h0;
    end
  end

  assign w_we        = mw_ld_reg && !mw_is_store && (mw_rd != 5'd0);
  assign w_rec_rd    = w_we ? mw_rd : 5'd0;
  assign w_rec_wdata = w_we ? w_sel_data : 32'h0;

  // Duplicate-tracking state and the retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_order <= '0;
      r_last_vld   <= 1'b0;
      r_commit_cnt <= 32'h0;
    end else if (w_accept) begin
      r_last_order <= mw_order;
      r_last_vld   <= 1'b1;
      r_commit_cnt <= r_commit_cnt + 32'd1;
    end
  end

  // Register-file write port: one-cycle enable, data held between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_rd    <= 5'd0;
      r_rf_wdata <= 32'h0;
    end else begin
      r_rf_we <= w_accept && w_we;
      if (w_accept) begin
        r_rf_rd    <= w_rec_rd;
        r_rf_wdata <= w_rec_wdata;
      end
    end
  end

  // Queue pointers and occupancy; simultaneous enqueue/dequeue leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if (w_deq)    r_rptr <= r_rptr + 1'b1;
      case ({w_accept, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents are masked at the outputs while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_q_order[r_wptr] <= mw_order;
      r_q_pc[r_wptr]    <= pc_rdata;
      r_q_rd[r_wptr]    <= w_rec_rd;
      r_q_wdata[r_wptr] <= w_rec_wdata;
    end
  end

  assign trc_valid  = (r_count != '0);
  assign trc_order  = trc_valid ? r_q_order[r_rptr] : '0;
  assign trc_pc     = trc_valid ? r_q_pc[r_rptr]    : 32'h0;
  assign trc_rd     = trc_valid ? r_q_rd[r_rptr]    : 5'd0;
  assign trc_wdata  = trc_valid ? r_q_wdata[r_rptr] : 32'h0;
  assign rf_we      = r_rf_we;
  assign rf_rd      = r_rf_rd;
  assign rf_wdata   = r_rf_wdata;
  assign commit_cnt = r_commit_cnt;

`ifdef WB_ORDER_CHECK_EN
  logic [ORDER_W-1:0] r_exp_order;
  logic               r_order_err;

  // Expected-tag tracker: flag any gap, then resync to the observed sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp_order <= '0;
      r_order_err <= 1'b0;
    end else if (w_accept) begin
      if (mw_order != r_exp_order) r_order_err <= 1'b1;
      r_exp_order <= mw_order + 1'b1;
    end
  end

  assign order_err = r_order_err;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// tb/tb_wb_commit_stage.sv - directed self-checking bench for wb_commit_stage
module tb_wb_commit_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mw_valid;
  logic        wb_ready;
  logic [63:0] mw_order;
  logic [3:0]  mw_sel;
  logic        mw_ld_reg;
  logic        mw_is_store;
  logic [4:0]  mw_rd;
  logic [31:0] alu_out;
  logic [31:0] u_imm;
  logic [31:0] mem_rdata;
  logic [31:0] pc_rdata;
  logic        br_en;
  logic [1:0]  mem_addr_lo;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        trc_valid;
  logic        trc_ready;
  logic [63:0] trc_order;
  logic [31:0] trc_pc;
  logic [4:0]  trc_rd;
  logic [31:0] trc_wdata;
  logic [31:0] commit_cnt;
  logic        order_err;

  int n_checks = 0;
  int n_errors = 0;

`ifdef WB_ORDER_CHECK_EN
  localparam logic EXP_ORDER_ERR = 1'b1;
`else
  localparam logic EXP_ORDER_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  wb_commit_stage #(.DEPTH(4), .ORDER_W(64)) dut (
    .clk(clk), .rst(rst), .mw_valid(mw_valid), .wb_ready(wb_ready),
    .mw_order(mw_order), .mw_sel(mw_sel), .mw_ld_reg(mw_ld_reg),
    .mw_is_store(mw_is_store), .mw_rd(mw_rd), .alu_out(alu_out),
    .u_imm(u_imm), .mem_rdata(mem_rdata), .pc_rdata(pc_rdata),
    .br_en(br_en), .mem_addr_lo(mem_addr_lo), .rf_we(rf_we),
    .rf_rd(rf_rd), .rf_wdata(rf_wdata), .trc_valid(trc_valid),
    .trc_ready(trc_ready), .trc_order(trc_order), .trc_pc(trc_pc),
    .trc_rd(trc_rd), .trc_wdata(trc_wdata), .commit_cnt(commit_cnt),
    .order_err(order_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mw_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic present(input logic [63:0] order, input logic [3:0] sel,
                         input logic ld, input logic st, input logic [4:0] rd);
    mw_valid    = 1'b1;
    mw_order    = order;
    mw_sel      = sel;
    mw_ld_reg   = ld;
    mw_is_store = st;
    mw_rd       = rd;
  endtask

  task automatic load_case(input string tag, input logic [63:0] order, input logic [3:0] sel,
                           input logic [1:0] lo, input logic [31:0] exp_data, input int exp_cnt);
    mem_addr_lo = lo;
    present(order, sel, 1'b1, 1'b0, 5'd5);
    tick();
    check({tag, "_we"}, rf_we, 1'b1);
    check({tag, "_rd"}, rf_rd, 5'd5);
    check({tag, "_wdata"}, rf_wdata, exp_data);
    check({tag, "_cnt"}, commit_cnt, exp_cnt);
    mw_valid = 1'b0;
    tick();
    check({tag, "_we_pulse"}, rf_we, 1'b0);
  endtask

  initial begin
    rst = 1'b1; mw_valid = 1'b0; mw_order = '0; mw_sel = '0; mw_ld_reg = 1'b0;
    mw_is_store = 1'b0; mw_rd = '0; alu_out = '0; u_imm = '0; mem_rdata = '0;
    pc_rdata = '0; br_en = 1'b0; mem_addr_lo = '0; trc_ready = 1'b0;

    do_reset();
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_trc_valid", trc_valid, 1'b0);
    check("rst_trc_order", trc_order, 64'h0);
    check("rst_commit_cnt", commit_cnt, 32'h0);
    check("rst_wb_ready", wb_ready, 1'b1);
    check("rst_order_err", order_err, 1'b0);

    // sub-word load alignment
    trc_ready = 1'b1;
    mem_rdata = 32'h8080_F0F0;
    load_case("lb_lo1",  64'd0, 4'd5, 2'd1, 32'hFFFF_FFF0, 1);
    load_case("lbu_lo3", 64'd1, 4'd6, 2'd3, 32'h0000_0080, 2);
    load_case("lh_lo2",  64'd2, 4'd7, 2'd2, 32'hFFFF_8080, 3);
    load_case("lhu_lo0", 64'd3, 4'd8, 2'd0, 32'h0000_F0F0, 4);
    check("load_drained", trc_valid, 1'b0);

    // duplicate suppression
    do_reset();
    trc_ready = 1'b0;
    alu_out = 32'h1234;
    pc_rdata = 32'h200;
    present(64'd7, 4'd0, 1'b1, 1'b0, 5'd3);
    tick();
    check("dup_we1", rf_we, 1'b1);
    check("dup_wdata", rf_wdata, 32'h1234);
    tick();
    check("dup_we2", rf_we, 1'b0);
    tick();
    check("dup_we3", rf_we, 1'b0);
    check("dup_cnt", commit_cnt, 32'd1);
    mw_valid = 1'b0;
    check("dup_trc_valid", trc_valid, 1'b1);
    check("dup_trc_order", trc_order, 64'd7);
    check("dup_trc_rd", trc_rd, 5'd3);
    check("dup_trc_wdata", trc_wdata, 32'h1234);
    check("dup_trc_pc", trc_pc, 32'h200);
    alu_out = 32'h5678;
    present(64'd8, 4'd0, 1'b1, 1'b0, 5'd3);
    tick();
    mw_valid = 1'b0;
    check("dup8_cnt", commit_cnt, 32'd2);
    check("dup8_wdata", rf_wdata, 32'h5678);
    trc_ready = 1'b1;
    tick();
    check("dup_second_rec", trc_order, 64'd8);
    check("dup_second_valid", trc_valid, 1'b1);
    tick();
    check("dup_drained", trc_valid, 1'b0);

    // full queue and same-cycle enqueue/dequeue
    do_reset();
    trc_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(64'(i), 4'd0, 1'b1, 1'b0, 5'd1);
      #4;
      check($sformatf("full_ready_%0d", i), wb_ready, 1'b1);
      tick();
    end
    present(64'd4, 4'd0, 1'b1, 1'b0, 5'd1);
    #4;
    check("full_ready_4", wb_ready, 1'b0);
    tick();
    check("full_cnt_held", commit_cnt, 32'd4);
    check("full_head0", trc_order, 64'd0);
    trc_ready = 1'b1;
    #4;
    check("full_ready_drain", wb_ready, 1'b1);
    tick();
    mw_valid = 1'b0;
    check("full_cnt5", commit_cnt, 32'd5);
    check("full_head1", trc_order, 64'd1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check($sformatf("full_head%0d", k), trc_order, 64'(k));
    end
    tick();
    check("full_empty", trc_valid, 1'b0);

    // store / x0 suppression and pc_plus4
    do_reset();
    trc_ready = 1'b0;
    alu_out = 32'hDEAD;
    pc_rdata = 32'h100;
    present(64'd0, 4'd0, 1'b1, 1'b1, 5'd4);
    tick();
    check("sw_we", rf_we, 1'b0);
    check("sw_trc_rd", trc_rd, 5'd0);
    check("sw_trc_wdata", trc_wdata, 32'h0);
    check("sw_trc_pc", trc_pc, 32'h100);
    present(64'd1, 4'd0, 1'b1, 1'b0, 5'd0);
    tick();
    check("x0_we", rf_we, 1'b0);
    pc_rdata = 32'h4000_0010;
    present(64'd2, 4'd4, 1'b1, 1'b0, 5'd1);
    tick();
    mw_valid = 1'b0;
    check("pc4_we", rf_we, 1'b1);
    check("pc4_rd", rf_rd, 5'd1);
    check("pc4_wdata", rf_wdata, 32'h4000_0014);

    // reset with three queued records
    check("pre_rst_cnt", commit_cnt, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_trc_valid", trc_valid, 1'b0);
    check("mid_rst_cnt", commit_cnt, 32'd0);
    check("mid_rst_ready", wb_ready, 1'b1);
    check("mid_rst_we", rf_we, 1'b0);
    alu_out = 32'h77;
    present(64'd0, 4'd0, 1'b1, 1'b0, 5'd2);
    tick();
    mw_valid = 1'b0;
    check("re0_cnt", commit_cnt, 32'd1);
    check("re0_we", rf_we, 1'b1);
    check("re0_trc_order", trc_order, 64'd0);
    check("re0_trc_valid", trc_valid, 1'b1);

    // order-sequence check
    do_reset();
    trc_ready = 1'b1;
    present(64'd0, 4'd0, 1'b1, 1'b0, 5'd1);
    tick();
    present(64'd1, 4'd0, 1'b1, 1'b0, 5'd1);
    tick();
    check("ord_err_clean", order_err, 1'b0);
    present(64'd3, 4'd0, 1'b1, 1'b0, 5'd1);
    tick();
    mw_valid = 1'b0;
    check("ord_err_gap", order_err, EXP_ORDER_ERR);
    tick();
    tick();
    check("ord_err_sticky", order_err, EXP_ORDER_ERR);
    check("ord_cnt", commit_cnt, 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
